// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Types shared by the block-RAM port arbiter.
//   arb_state_t : port ownership state (no owner, owned by requester 0 or 1)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one port of the 1024x16 dual-port block RAM between requester 0
//   (CPU data path) and requester 1 (peripheral / display fetch). Arbitration
//   is round-robin with a bounded burst: an owner keeps the port for at most
//   BURST_MAX consecutive grants while the other side is waiting.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*       requester inputs; req held until granted
//   gnt*                        combinational grant (transfer on req & gnt)
//   rvalid*/rdata*              read return, valid 1 cycle after the grant
//   ram_we/ram_addr/ram_wdata   muxed RAM port controls
//   ram_rdata                   registered RAM read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // beat_cnt must hold 0..BURST_MAX inclusive.
  localparam int            CW       = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BEAT_MAX = CW'(BURST_MAX);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          last_q, last_d;
  logic          win_valid;
  logic          win_id;

  // Returns {valid, id}. With both requesting, the current owner keeps the
  // port until its burst is used up; from IDLE the previous loser goes first.
  function automatic logic [1:0] pick_winner(
    input logic          r0,
    input logic          r1,
    input arb_state_t    st,
    input logic [CW-1:0] beat,
    input logic          last
  );
    logic [1:0] res;
    res = 2'b00;
    if (r0 && r1) begin
      unique case (st)
        ST_OWN0: res = {1'b1, (beat < BEAT_MAX) ? 1'b0 : 1'b1};
        ST_OWN1: res = {1'b1, (beat < BEAT_MAX) ? 1'b1 : 1'b0};
        default: res = {1'b1, ~last};
      endcase
    end else if (r0) begin
      res = 2'b10;
    end else if (r1) begin
      res = 2'b11;
    end
    return res;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d              = state_q;
    beat_d               = beat_q;
    last_d               = last_q;
    {win_valid, win_id}  = pick_winner(req0, req1, state_q, beat_q, last_q);

    if (win_valid) begin
      last_d = win_id;
      if (state_q == (win_id ? ST_OWN1 : ST_OWN0)) begin
        // Saturate so an uncontested owner can stream indefinitely.
        beat_d = (beat_q == BEAT_MAX) ? beat_q : beat_q + CW'(1);
      end else begin
        state_d = win_id ? ST_OWN1 : ST_OWN0;
        beat_d  = CW'(1);
      end
    end else begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end
  end

  // Grants are forced low while reset is asserted, independent of the clock.
  assign gnt0 = rst_n & win_valid & ~win_id;
  assign gnt1 = rst_n & win_valid &  win_id;

  // With no grant the port shows requester 0's inputs and never writes.
  assign ram_we    = (gnt0 & we0) | (gnt1 & we1);
  assign ram_addr  = gnt1 ? addr1  : addr0;
  assign ram_wdata = gnt1 ? wdata1 : wdata0;

  // The RAM output is already registered, so it passes straight through.
  assign rdata0 = ram_rdata;
  assign rdata1 = ram_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      last_q  <= 1'b1;  // requester 0 wins the first contest
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

endmodule : mem_port_arbiter
